// File: rtl/transmit_stream_if.sv
// Handshake and store-write bundle for transmit_stream.
// master: the streamer (drives t_o_*); slave: the requester/consumer side.
interface transmit_stream_if #(
   parameter int IWIDTH = 32,
   parameter int AWIDTH = 3
);
   logic              t_i_we;
   logic [AWIDTH-1:0] t_i_waddr;
   logic [IWIDTH-1:0] t_i_wdata;
   logic              t_i_syn;
   logic [AWIDTH-1:0] t_i_base;
   logic [AWIDTH:0]   t_i_len;
   logic              t_i_ready;
   logic [IWIDTH-1:0] t_o_instr;
   logic              t_o_valid;
   logic              t_o_last;
   logic              t_o_ack;
   logic              t_o_err;
   logic              t_o_busy;

   modport master (
      input  t_i_we, t_i_waddr, t_i_wdata, t_i_syn, t_i_base, t_i_len, t_i_ready,
      output t_o_instr, t_o_valid, t_o_last, t_o_ack, t_o_err, t_o_busy
   );

   modport slave (
      output t_i_we, t_i_waddr, t_i_wdata, t_i_syn, t_i_base, t_i_len, t_i_ready,
      input  t_o_instr, t_o_valid, t_o_last, t_o_ack, t_o_err, t_o_busy
   );
endinterface

// File: rtl/transmit_stream.sv
// transmit_stream: plays a window [base, base+len) of a local instruction
// store onto a valid/ready stream, tags the final word, and pulses ack on
// completion or err on rejection.
// Build option: define TRANSMIT_WRAP_EN to allow windows that run past the
// end of the store (the read pointer wraps to 0); otherwise they are rejected.
module transmit_stream #(
   parameter int IWIDTH = 32,
   parameter int DEPTH  = 7,
   parameter int AWIDTH = 3
) (
   input  logic              t_clk,
   input  logic              t_rst,
   transmit_stream_if.master t_bus
);

   localparam logic [AWIDTH:0]   DEPTH_W = DEPTH[AWIDTH:0];
   localparam logic [AWIDTH-1:0] LAST_A  = AWIDTH'(DEPTH - 1);
   localparam logic [AWIDTH:0]   ONE_W   = {{AWIDTH{1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

   state_t            r_state;
   logic [IWIDTH-1:0] r_mem [DEPTH];
   logic [AWIDTH-1:0] r_ptr;
   logic [AWIDTH:0]   r_rem;
   logic [IWIDTH-1:0] r_instr;
   logic              r_valid;
   logic              r_last;
   logic              r_ack;
   logic              r_err;

   logic [IWIDTH-1:0] w_rdata;
   logic [AWIDTH-1:0] w_ptr_nxt;
   logic              w_overrun;
   logic              w_reject;

   // Store write port; out-of-range addresses are dropped, no reset on contents
   always_ff @(posedge t_clk) begin
      if (t_bus.t_i_we && ({1'b0, t_bus.t_i_waddr} < DEPTH_W)) begin
         r_mem[t_bus.t_i_waddr] <= t_bus.t_i_wdata;
      end
   end

   assign w_rdata   = r_mem[r_ptr];
   assign w_ptr_nxt = (r_ptr == LAST_A) ? '0 : r_ptr + 1'b1;

`ifdef TRANSMIT_WRAP_EN
   assign w_overrun = 1'b0;
`else
   logic [AWIDTH+1:0] w_end;
   // Two extra bits so base+len cannot overflow before the range checks apply
   assign w_end     = {2'b00, t_bus.t_i_base} + {1'b0, t_bus.t_i_len};
   assign w_overrun = (w_end > {1'b0, DEPTH_W});
`endif

   // Request validation: empty window, base outside store, or oversize window
   always_comb begin
      w_reject = (t_bus.t_i_len == '0)
              || ({1'b0, t_bus.t_i_base} >= DEPTH_W)
              || (t_bus.t_i_len > DEPTH_W)
              || w_overrun;
   end

   // Request FSM with registered stream outputs and one-cycle ack/err pulses
   always_ff @(posedge t_clk) begin
      if (t_rst) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_rem   <= '0;
         r_instr <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (t_bus.t_i_syn) begin
                  if (w_reject) begin
                     r_err <= 1'b1;
                  end else begin
                     r_ptr   <= t_bus.t_i_base;
                     r_rem   <= t_bus.t_i_len;
                     r_state <= FETCH;
                  end
               end
            end
            FETCH: begin
               r_instr <= w_rdata;
               r_valid <= 1'b1;
               r_last  <= (r_rem == ONE_W);
               r_ptr   <= w_ptr_nxt;
               r_rem   <= r_rem - ONE_W;
               r_state <= SEND;
            end
            SEND: begin
               if (r_valid && t_bus.t_i_ready) begin
                  if (r_last) begin
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                     r_ack   <= 1'b1;
                     r_state <= IDLE;
                  end else begin
                     // r_rem counts words not yet loaded, so ==1 marks the next load as final
                     r_instr <= w_rdata;
                     r_last  <= (r_rem == ONE_W);
                     r_ptr   <= w_ptr_nxt;
                     r_rem   <= r_rem - ONE_W;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign t_bus.t_o_instr = r_instr;
   assign t_bus.t_o_valid = r_valid;
   assign t_bus.t_o_last  = r_last;
   assign t_bus.t_o_ack   = r_ack;
   assign t_bus.t_o_err   = r_err;
   assign t_bus.t_o_busy  = (r_state != IDLE);

endmodule

// File: tb/tb_transmit_stream.sv
// Bench for transmit_stream: table of requests applied in a loop, expected
// words queued at request time and compared by a monitor as they stream out,
// plus hand-written reset-abort and held-start sequences.
module tb_transmit_stream;

   localparam int IW    = 32;
   localparam int DEPTH = 7;
   localparam int AW    = 3;

   logic t_clk = 1'b0;
   logic t_rst;

   always #5 t_clk = ~t_clk;

   transmit_stream_if #(.IWIDTH(IW), .AWIDTH(AW)) bus ();

   transmit_stream #(.IWIDTH(IW), .DEPTH(DEPTH), .AWIDTH(AW)) dut (
      .t_clk (t_clk),
      .t_rst (t_rst),
      .t_bus (bus.master)
   );

   typedef struct {
      logic [IW-1:0] w;
      logic          l;
   } exp_t;

   typedef struct {
      logic [AW-1:0] base;
      logic [AW:0]   len;
      logic [15:0]   rdy;
      bit            rej;
      int            cyc;
   } req_t;

   int            n_chk   = 0;
   int            n_err   = 0;
   int            ack_cnt = 0;
   int            err_cnt = 0;
   logic [IW-1:0] model [DEPTH];
   exp_t          sb [$];
   req_t          tbl [7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge t_clk);
      #1;
   endtask

   task automatic write_mem(input int a, input logic [IW-1:0] d);
      bus.t_i_we    = 1'b1;
      bus.t_i_waddr = AW'(a);
      bus.t_i_wdata = d;
      tick();
      bus.t_i_we = 1'b0;
      if (a < DEPTH) model[a] = d;
   endtask

   task automatic push_window(input int base, input int len);
      exp_t e;
      for (int k = 0; k < len; k++) begin
         e.w = model[(base + k) % DEPTH];
         e.l = (k == len - 1);
         sb.push_back(e);
      end
   endtask

   // Monitor: every presented word must match the queue head; pop on transfer
   always @(negedge t_clk) begin
      if (!t_rst) begin
         if (bus.t_o_ack) ack_cnt++;
         if (bus.t_o_err) err_cnt++;
         if (bus.t_o_valid) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL unexpected_word: got %0h expected none", bus.t_o_instr);
            end else begin
               chk("word", bus.t_o_instr, sb[0].w);
               chk("last", bus.t_o_last, sb[0].l);
               if (bus.t_i_ready) void'(sb.pop_front());
            end
         end
      end
   end

   task automatic run_req(input req_t r);
      int a0;
      int e0;
      int cyc;
      a0 = ack_cnt;
      e0 = err_cnt;
      if (!r.rej) push_window(int'(r.base), int'(r.len));
      bus.t_i_syn   = 1'b1;
      bus.t_i_base  = r.base;
      bus.t_i_len   = r.len;
      bus.t_i_ready = 1'b0;
      tick();
      bus.t_i_syn = 1'b0;
      if (r.rej) begin
         chk("rej_err", bus.t_o_err, 1);
         chk("rej_busy", bus.t_o_busy, 0);
         chk("rej_valid", bus.t_o_valid, 0);
         tick();
         chk("rej_err_end", bus.t_o_err, 0);
         chk("rej_valid2", bus.t_o_valid, 0);
         chk("rej_busy2", bus.t_o_busy, 0);
         tick();
         chk("rej_err_count", err_cnt - e0, 1);
         chk("rej_no_ack", ack_cnt - a0, 0);
      end else begin
         chk("start_busy", bus.t_o_busy, 1);
         chk("start_valid", bus.t_o_valid, 0);
         tick();
         chk("first_valid", bus.t_o_valid, 1);
         cyc = 0;
         while (!bus.t_o_ack && cyc < 64) begin
            bus.t_i_ready = (cyc < 16) ? r.rdy[cyc] : 1'b1;
            tick();
            cyc++;
         end
         bus.t_i_ready = 1'b0;
         chk("cycles_to_ack", cyc, r.cyc);
         chk("ack", bus.t_o_ack, 1);
         chk("ack_busy", bus.t_o_busy, 0);
         chk("ack_valid", bus.t_o_valid, 0);
         chk("sb_empty", sb.size(), 0);
         tick();
         chk("ack_end", bus.t_o_ack, 0);
         chk("ack_count", ack_cnt - a0, 1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int   a0;
      int   cyc;
      exp_t e;

      tbl[0] = '{3'd0, 4'd7, 16'hFFFF, 1'b0, 7};
      tbl[1] = '{3'd2, 4'd3, 16'h0019, 1'b0, 5};
`ifdef TRANSMIT_WRAP_EN
      tbl[2] = '{3'd5, 4'd4, 16'hFFFF, 1'b0, 4};
`else
      tbl[2] = '{3'd5, 4'd4, 16'hFFFF, 1'b1, 0};
`endif
      tbl[3] = '{3'd0, 4'd0, 16'hFFFF, 1'b1, 0};
      tbl[4] = '{3'd0, 4'd8, 16'hFFFF, 1'b1, 0};
      tbl[5] = '{3'd7, 4'd1, 16'hFFFF, 1'b1, 0};
      tbl[6] = '{3'd6, 4'd1, 16'hFFFF, 1'b0, 1};

      t_rst         = 1'b1;
      bus.t_i_we    = 1'b0;
      bus.t_i_waddr = '0;
      bus.t_i_wdata = '0;
      bus.t_i_syn   = 1'b0;
      bus.t_i_base  = '0;
      bus.t_i_len   = '0;
      bus.t_i_ready = 1'b0;
      tick();
      tick();
      chk("rst_instr", bus.t_o_instr, 0);
      chk("rst_valid", bus.t_o_valid, 0);
      chk("rst_last", bus.t_o_last, 0);
      chk("rst_ack", bus.t_o_ack, 0);
      chk("rst_err", bus.t_o_err, 0);
      chk("rst_busy", bus.t_o_busy, 0);
      t_rst = 1'b0;
      tick();

      for (int i = 0; i < DEPTH; i++) write_mem(i, 32'h1000_0000 + 32'(i));

      for (int i = 0; i < 7; i++) run_req(tbl[i]);

      // Reset while the third word of a full-store request is on the bus
      a0 = ack_cnt;
      push_window(0, 7);
      bus.t_i_syn   = 1'b1;
      bus.t_i_base  = 3'd0;
      bus.t_i_len   = 4'd7;
      bus.t_i_ready = 1'b1;
      tick();
      bus.t_i_syn = 1'b0;
      tick();
      tick();
      tick();
      chk("pre_rst_word", bus.t_o_instr, 32'h1000_0002);
      t_rst = 1'b1;
      tick();
      t_rst = 1'b0;
      bus.t_i_ready = 1'b0;
      chk("abort_instr", bus.t_o_instr, 0);
      chk("abort_valid", bus.t_o_valid, 0);
      chk("abort_last", bus.t_o_last, 0);
      chk("abort_ack", bus.t_o_ack, 0);
      chk("abort_err", bus.t_o_err, 0);
      chk("abort_busy", bus.t_o_busy, 0);
      sb.delete();
      tick();
      tick();
      chk("abort_no_ack", ack_cnt - a0, 0);
      run_req('{3'd3, 4'd2, 16'hFFFF, 1'b0, 2});

      // Start held high: second request starts at the ack edge and sees a
      // store write that landed on the same edge the first request read it
      a0 = ack_cnt;
      e.w = model[0]; e.l = 1'b0; sb.push_back(e);
      e.w = model[1]; e.l = 1'b1; sb.push_back(e);
      e.w = model[0]; e.l = 1'b0; sb.push_back(e);
      e.w = 32'hCAFE_0001; e.l = 1'b1; sb.push_back(e);
      bus.t_i_syn   = 1'b1;
      bus.t_i_base  = 3'd0;
      bus.t_i_len   = 4'd2;
      bus.t_i_ready = 1'b1;
      tick();
      tick();
      bus.t_i_we    = 1'b1;
      bus.t_i_waddr = 3'd1;
      bus.t_i_wdata = 32'hCAFE_0001;
      tick();
      bus.t_i_we = 1'b0;
      model[1]   = 32'hCAFE_0001;
      tick();
      chk("held_ack1", bus.t_o_ack, 1);
      chk("held_ack1_busy", bus.t_o_busy, 0);
      tick();
      chk("held_restart_busy", bus.t_o_busy, 1);
      bus.t_i_syn = 1'b0;
      cyc = 0;
      while (!bus.t_o_ack && cyc < 16) begin
         tick();
         cyc++;
      end
      bus.t_i_ready = 1'b0;
      chk("held_ack2", bus.t_o_ack, 1);
      chk("held_sb_empty", sb.size(), 0);
      tick();
      chk("held_ack_count", ack_cnt - a0, 2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/transmit_stream.md
# transmit_stream

Parametrised instruction streamer: a local instruction store, written through a simple write port, plays a programmable window of words onto a valid/ready stream feeding the MIPS fetch side. Each request is a start pulse with base address and length. Every word is presented with backpressure, the final word is tagged, and completion or rejection is reported with a one-cycle pulse. This block generalises the fixed-length, no-backpressure instruction transmitter.

## Interface
- IWIDTH, 32, instruction word width
- DEPTH, 7, number of words in the instruction store (1..2^AWIDTH)
- AWIDTH, 3, store address width
- t_clk  in  1  clock; all logic on rising edge
- t_rst  in  1  reset; synchronous, active-high
- t_i_we  in  1  store write enable
- t_i_waddr  in  AWIDTH  store write address (writes with address >= DEPTH ignored)
- t_i_wdata  in  IWIDTH  store write data
- t_i_syn  in  1  start request, sampled only in IDLE
- t_i_base  in  AWIDTH  first word address, sampled with t_i_syn
- t_i_len  in  AWIDTH+1  number of words to send, sampled with t_i_syn
- t_i_ready  in  1  downstream accepts the current word
- t_o_instr  out  IWIDTH  current word
- t_o_valid  out  1  t_o_instr valid
- t_o_last  out  1  current word is the final word of the request
- t_o_ack  out  1  one-cycle pulse after the final word is accepted
- t_o_err  out  1  one-cycle pulse when a request is rejected
- t_o_busy  out  1  request in progress

## Operation
- Store: DEPTH x IWIDTH register array with asynchronous read. Writes take effect at the edge, so a same-edge read returns the old value. Writes are allowed at any time. The store is not cleared by reset.
- FSM states: IDLE, FETCH, SEND.
- IDLE, t_i_syn=1:
  - If t_i_len==0, t_i_base>=DEPTH, or t_i_len>DEPTH: pulse t_o_err and stay in IDLE.
  - If the window overruns (see Configuration): pulse t_o_err and stay in IDLE.
  - Otherwise: capture the base address into the read pointer and the length into the remaining-word counter, then go to FETCH.
- FETCH:
  - t_o_instr <= mem[ptr]; t_o_valid <= 1; t_o_last <= (remaining==1).
  - Advance ptr and decrement remaining; go to SEND.
- SEND:
  - A transfer occurs on an edge where t_o_valid & t_i_ready.
  - Transfer of a non-last word: load the next word (mem[ptr]), update t_o_last, advance ptr, and decrement remaining. This gives one word per cycle under continuous ready.
  - Transfer of the last word: t_o_valid <= 0, t_o_last <= 0, t_o_ack <= 1, go to IDLE.
  - With t_i_ready=0, t_o_instr, t_o_valid and t_o_last hold stable.
- Pointer advance: ptr+1, and ptr==DEPTH-1 goes to 0.
- t_o_busy = (state != IDLE).
- t_i_syn while busy is ignored. It is not queued.

## Timing
- Reset values: t_o_instr=0, t_o_valid=0, t_o_last=0, t_o_ack=0, t_o_err=0, t_o_busy=0; state IDLE; ptr and counter 0.
- Reset mid-request: the request is aborted with no ack, and the outputs above apply after the reset edge.
- Start latency: with t_i_syn sampled at edge N, t_o_busy=1 after N and t_o_valid=1 after N+1.
- Throughput: with t_i_ready held high, len words occupy consecutive cycles. t_o_ack is high in the cycle after the last transfer, and t_o_busy is low in that same cycle.
- t_o_err is high in the cycle after the rejecting edge.
- A new request is accepted at the edge where t_o_ack is high (state is already IDLE).
- Same-edge write to the address being fetched: the old word is sent. The new word is seen only if that address is read again later.

## Configuration
- TRANSMIT_WRAP_EN defined: a window with t_i_base+t_i_len > DEPTH is legal. The pointer wraps to 0 after DEPTH-1.
- TRANSMIT_WRAP_EN undefined: such a window is rejected with t_o_err, and no words are sent.
- All other checks apply in both builds.

## Test plan
- Load mem[i]=0x1000_0000+i for i=0..6; base=0, len=7, ready=1 -> 7 words 0x10000000..0x10000006 on consecutive cycles; last with word 6; ack one cycle later.
- base=2, len=3, ready toggling 1,0,0,1,1 -> words 0x10000002, 0x10000003, 0x10000004 each held while ready=0; last only on 0x10000004; exactly one ack.
- base=5, len=4 -> with TRANSMIT_WRAP_EN: words 5, 6, 0, 1 then ack; without it: t_o_err pulse, t_o_valid stays 0.
- len=0, len=8, and base=7 requests -> one t_o_err pulse each, no valid, no ack, busy stays 0.
- Assert t_rst during the 3rd word of a len=7 request -> all outputs 0 next cycle, no ack; a fresh request then streams from its own base.
- t_i_syn held high through a len=2 request -> first request completes; the second starts at the ack edge; a write to mem[1] during the first request is reflected in the second.
